// File: rtl/ff_pkg.sv
// Shared types and constants for the foodfight input conditioner.
package ff_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PULSE,
      ST_LOCK
   } coin_state_t;

   localparam int unsigned TEST    = 0;
   localparam int unsigned THROW2  = 1;
   localparam int unsigned THROW1  = 2;
   localparam int unsigned COINAUX = 3;
   localparam int unsigned START2  = 4;
   localparam int unsigned START1  = 5;
   localparam int unsigned COIN2   = 6;
   localparam int unsigned COIN1   = 7;
   localparam int unsigned CNTRR   = 8;
   localparam int unsigned CNTRL   = 9;

   localparam logic [9:0] DEF_COIN_MASK = 10'b0011001000;

   function automatic int unsigned umax(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ff_input_cond_if.sv
// Switch-side bundle between the board inputs and the conditioner outputs.
interface ff_input_cond_if #(
   parameter int unsigned NCH = 10
);
   logic [NCH-1:0] raw_in;
   logic [NCH-1:0] level_out;
   logic [NCH-1:0] rise;
   logic [NCH-1:0] fall;
   logic [NCH-1:0] coin_out;
   logic           coin_drop;

   modport master (output raw_in, input level_out, rise, fall, coin_out, coin_drop);
   modport slave  (input raw_in, output level_out, rise, fall, coin_out, coin_drop);
endinterface

// File: rtl/ff_debounce.sv
// One channel: 2-flop synchroniser, counter debouncer, registered edge pulses.
module ff_debounce #(
   parameter int unsigned DB_CYCLES = 12000
) (
   input  logic clk12m,
   input  logic reset,
   input  logic n_in,
   output logic level,
   output logic rise,
   output logic fall,
   output logic rise_nxt
);
   localparam int unsigned CW = $clog2(DB_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;
   logic          accept;

   // accept is the edge on which level takes the synchronised value
   assign accept   = (sync2 != level) && (cnt == LAST);
   assign rise_nxt = accept && sync2;

   always_ff @(posedge clk12m or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= n_in;
         sync2 <= sync1;
         rise  <= rise_nxt;
         fall  <= accept && !sync2;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (accept) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/ff_input_cond.sv
// Input conditioner: per-channel debounce plus coin pulse stretch and lockout.
module ff_input_cond
   import ff_pkg::*;
#(
   parameter int unsigned    NCH          = 10,
   parameter int unsigned    DB_CYCLES    = 12000,
   parameter logic [NCH-1:0] INVERT       = '0,
   parameter logic [NCH-1:0] COIN_MASK    = NCH'(DEF_COIN_MASK),
   parameter int unsigned    COIN_STRETCH = 4,
   parameter int unsigned    COIN_LOCK    = 120000
) (
   input logic           clk12m,
   input logic           reset,
   ff_input_cond_if.slave io
);
   localparam int unsigned    CCW    = $clog2(umax(COIN_STRETCH, COIN_LOCK)) + 1;
   localparam logic [CCW-1:0] S_LAST = CCW'(COIN_STRETCH - 1);
   localparam logic [CCW-1:0] L_LAST = CCW'((COIN_LOCK > 0) ? COIN_LOCK - 1 : 0);

   logic [NCH-1:0] rise_nxt;
   logic [NCH-1:0] drop_vec;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      ff_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clk12m   (clk12m),
         .reset    (reset),
         .n_in     (io.raw_in[i] ^ INVERT[i]),
         .level    (io.level_out[i]),
         .rise     (io.rise[i]),
         .fall     (io.fall[i]),
         .rise_nxt (rise_nxt[i])
      );

      if (COIN_MASK[i]) begin : g_coin
         coin_state_t    st, st_nxt;
         logic [CCW-1:0] cnt, cnt_nxt;
         logic           drop_c;

         always_ff @(posedge clk12m or negedge reset) begin
            if (!reset) begin
               st  <= ST_IDLE;
               cnt <= '0;
            end else begin
               st  <= st_nxt;
               cnt <= cnt_nxt;
            end
         end

         // a rise on the edge where LOCK expires restarts the pulse without a drop
         always_comb begin
            st_nxt  = st;
            cnt_nxt = cnt;
            drop_c  = 1'b0;
            case (st)
               ST_IDLE: begin
                  if (rise_nxt[i]) begin
                     st_nxt  = ST_PULSE;
                     cnt_nxt = '0;
                  end
               end
               ST_PULSE: begin
                  drop_c = rise_nxt[i];
                  if (cnt == S_LAST) begin
                     cnt_nxt = '0;
                     st_nxt  = (COIN_LOCK == 0) ? ST_IDLE : ST_LOCK;
                  end else begin
                     cnt_nxt = cnt + CCW'(1);
                  end
               end
               ST_LOCK: begin
                  if (cnt == L_LAST) begin
                     cnt_nxt = '0;
                     st_nxt  = rise_nxt[i] ? ST_PULSE : ST_IDLE;
                  end else begin
                     cnt_nxt = cnt + CCW'(1);
                     drop_c  = rise_nxt[i];
                  end
               end
               default: begin
                  st_nxt  = ST_IDLE;
                  cnt_nxt = '0;
               end
            endcase
         end

         assign io.coin_out[i] = (st == ST_PULSE);
         assign drop_vec[i]    = drop_c;
      end else begin : g_plain
         assign io.coin_out[i] = 1'b0;
         assign drop_vec[i]    = 1'b0;
      end
   end

   always_ff @(posedge clk12m or negedge reset) begin
      if (!reset) io.coin_drop <= 1'b0;
      else        io.coin_drop <= |drop_vec;
   end
endmodule

// File: tb/tb_ff_input_cond.sv
// Directed and randomised checks of ff_input_cond against a sliding-window reference model.
module tb_ff_input_cond;
   localparam int unsigned NCH   = 10;
   localparam int unsigned DB    = 4;
   localparam int unsigned CS    = 3;
   // lock long enough that a debounced re-press can land inside it
   localparam int unsigned CL    = 9;
   localparam logic [9:0]  INV   = 10'b0000010000;
   localparam logic [9:0]  CMASK = 10'b0011001000;

   logic       clk12m = 1'b0;
   logic       reset  = 1'b0;
   logic [9:0] raw    = INV;

   int checks   = 0;
   int failures = 0;

   ff_input_cond_if #(.NCH(NCH)) io ();
   assign io.raw_in = raw;

   ff_input_cond #(
      .NCH          (NCH),
      .DB_CYCLES    (DB),
      .INVERT       (INV),
      .COIN_MASK    (CMASK),
      .COIN_STRETCH (CS),
      .COIN_LOCK    (CL)
   ) dut (
      .clk12m (clk12m),
      .reset  (reset),
      .io     (io)
   );

   always #5 clk12m = ~clk12m;

   // reference model: level flips when the last DB synchronised samples all disagree with it
   logic [9:0] hq [$];
   logic [9:0] m_level, m_rise, m_fall, m_coin;
   logic       m_drop;
   int         edge_no;
   int         acc_edge [10];
   int         free_at  [10];
   int         obs_hi7, obs_hi6, obs_drop, obs_c2;

   task automatic model_reset();
      hq.delete();
      for (int unsigned j = 0; j < DB + 1; j++) hq.push_back('0);
      m_level = '0; m_rise = '0; m_fall = '0; m_coin = '0; m_drop = 1'b0;
      edge_no = 0;
      for (int c = 0; c < 10; c++) begin
         acc_edge[c] = -1000;
         free_at[c]  = 0;
      end
   endtask

   task automatic model_edge();
      logic [9:0] w;
      bit flip;
      hq.push_back(raw ^ INV);
      if (hq.size() > DB + 2) void'(hq.pop_front());
      edge_no++;
      m_rise = '0; m_fall = '0; m_drop = 1'b0;
      for (int c = 0; c < 10; c++) begin
         flip = 1'b1;
         for (int unsigned j = 0; j < DB; j++) begin
            w = hq[j];
            if (w[c] == m_level[c]) flip = 1'b0;
         end
         if (flip) begin
            m_level[c] = ~m_level[c];
            if (m_level[c]) m_rise[c] = 1'b1;
            else            m_fall[c] = 1'b1;
         end
         if (CMASK[c] && m_rise[c]) begin
            if (edge_no >= free_at[c]) begin
               acc_edge[c] = edge_no;
               free_at[c]  = edge_no + CS + CL;
            end else begin
               m_drop = 1'b1;
            end
         end
         m_coin[c] = CMASK[c] && (edge_no - acc_edge[c] < CS);
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("level_out", 16'(io.level_out), 16'(m_level));
      chk("rise",      16'(io.rise),      16'(m_rise));
      chk("fall",      16'(io.fall),      16'(m_fall));
      chk("coin_out",  16'(io.coin_out),  16'(m_coin));
      chk("coin_drop", 16'(io.coin_drop), 16'(m_drop));
   endtask

   task automatic cyc();
      @(posedge clk12m);
      if (reset) model_edge();
      #1;
      check_all();
      obs_hi7  += int'(io.coin_out[7]);
      obs_hi6  += int'(io.coin_out[6]);
      obs_drop += int'(io.coin_drop);
      obs_c2   += int'(io.coin_out[2]);
   endtask

   task automatic hold(input logic [9:0] mask, input bit v, input int n);
      for (int k = 0; k < n; k++) begin
         raw = v ? (raw | mask) : (raw & ~mask);
         cyc();
      end
   endtask

   task automatic clr_obs();
      obs_hi7 = 0; obs_hi6 = 0; obs_drop = 0; obs_c2 = 0;
   endtask

   initial begin
      int sticky;
      model_reset();
      clr_obs();

      // reset with all inputs idle, bit 4 inverted and idling high
      repeat (3) cyc();
      reset = 1'b1;
      repeat (8) cyc();

      // single channel rise/fall latency
      raw[0] = 1'b1;
      repeat (5) cyc();
      chk("lat_rise_pre", 16'(io.level_out[0]), 16'd0);
      cyc();
      chk("lat_rise_lvl", 16'(io.level_out[0]), 16'd1);
      chk("lat_rise_pls", 16'(io.rise[0]), 16'd1);
      cyc();
      chk("lat_rise_one", 16'(io.rise[0]), 16'd0);
      raw[0] = 1'b0;
      repeat (5) cyc();
      chk("lat_fall_pre", 16'(io.level_out[0]), 16'd1);
      cyc();
      chk("lat_fall_pls", 16'(io.fall[0]), 16'd1);
      repeat (3) cyc();

      // short glitch rejected
      sticky = 0;
      hold(10'b0000000010, 1'b1, 3);
      sticky += int'(io.level_out[1] | io.rise[1] | io.fall[1]);
      for (int k = 0; k < 10; k++) begin
         hold(10'b0000000010, 1'b0, 1);
         sticky += int'(io.level_out[1] | io.rise[1] | io.fall[1]);
      end
      chk("glitch", 16'(sticky), 16'd0);

      // inverted channel asserted by driving low
      hold(10'b0000010000, 1'b0, 6);
      chk("invert_lvl", 16'(io.level_out[4]), 16'd1);
      hold(10'b0000010000, 1'b1, 8);

      // coin re-press inside lock then after lock
      clr_obs();
      for (int r = 0; r < 2; r++) begin
         hold(10'b0010000000, 1'b1, 4);
         hold(10'b0010000000, 1'b0, 4);
      end
      hold(10'b0010000000, 1'b1, 4);
      hold(10'b0010000000, 1'b0, 24);
      chk("coinA_hi", 16'(obs_hi7), 16'd6);
      chk("coinA_drop", 16'(obs_drop), 16'd1);

      // re-press landing exactly on lock expiry
      clr_obs();
      hold(10'b0010000000, 1'b1, 4);
      hold(10'b0010000000, 1'b0, 8);
      hold(10'b0010000000, 1'b1, 4);
      hold(10'b0010000000, 1'b0, 24);
      chk("coinB_hi", 16'(obs_hi7), 16'd6);
      chk("coinB_drop", 16'(obs_drop), 16'd0);

      // two coins together, non-coin channel active
      clr_obs();
      hold(10'b0011000100, 1'b1, 6);
      hold(10'b0011000000, 1'b0, 6);
      hold(10'b0000000100, 1'b0, 20);
      chk("dual_hi7", 16'(obs_hi7), 16'd3);
      chk("dual_hi6", 16'(obs_hi6), 16'd3);
      chk("noncoin", 16'(obs_c2), 16'd0);

      // randomised toggling on every channel
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < 10; c++)
            if ($urandom_range(5) == 0) raw[c] = ~raw[c];
         cyc();
      end

      // asynchronous reset in the middle of a coin pulse
      raw = INV;
      repeat (30) cyc();
      raw[3] = 1'b1;
      sticky = 0;
      for (int t = 0; t < 20 && !io.coin_out[3]; t++) cyc();
      chk("async_pre", 16'(io.coin_out[3]), 16'd1);
      #2 reset = 1'b0;
      model_reset();
      #1 check_all();
      repeat (2) cyc();
      reset = 1'b1;
      raw = INV;
      repeat (10) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
